// File: rtl/led_panel_driver.sv
// Front-panel LED driver: picks the cylon pattern, live status with stretched
// event flashes, or lamp test, then applies global PWM dimming on a registered output.
// The event-pulse input is named event_pulse because "event" is a SystemVerilog keyword.
module led_panel_driver #(
   parameter int PWMPRE         = 4,
   parameter int STRPRE         = 20,
   parameter int STRLEN         = 3,
   parameter int DBNC           = 4,
   parameter bit LED_ACTIVE_LOW = 1'b1
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic [7:0] cylon_q,
   input  logic [7:0] status,
   input  logic       status_vld,
   input  logic [7:0] event_pulse,
   input  logic       lamp_test,
   input  logic [2:0] bright,
   output logic [7:0] led,
   output logic [1:0] mode
);

   typedef enum logic [1:0] {
      BOOT = 2'd0,
      RUN  = 2'd1,
      LAMP = 2'd2
   } state_t;

   localparam logic [7:0] LED_OFF = LED_ACTIVE_LOW ? 8'hFF : 8'h00;

   state_t            state;
   state_t            state_next;
   logic [3:0]        dbcnt;
   logic              vld_db;
   logic [STRPRE-1:0] strcnt;
   logic              tick;
   logic [2:0]        scnt [8];
   logic [7:0]        flash;
   logic              pwm_step;
   logic [2:0]        pwm;
   logic              on;
   logic [7:0]        pattern;
   logic              lit;
   logic [7:0]        led_next;

   // vld_db only follows status_vld after DBNC consecutive disagreeing clocks
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         dbcnt  <= 4'd0;
         vld_db <= 1'b0;
      end else if (status_vld == vld_db) begin
         dbcnt <= 4'd0;
      end else if (dbcnt == 4'(DBNC - 1)) begin
         vld_db <= ~vld_db;
         dbcnt  <= 4'd0;
      end else begin
         dbcnt <= dbcnt + 4'd1;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state <= BOOT;
      end else begin
         state <= state_next;
      end
   end

   // Lamp test overrides everything; otherwise the debounced valid picks RUN vs BOOT
   always_comb begin
      state_next = state;
      if (lamp_test) begin
         state_next = LAMP;
      end else begin
         case (state)
            LAMP:    state_next = vld_db ? RUN : BOOT;
            BOOT:    if (vld_db) state_next = RUN;
            RUN:     if (!vld_db) state_next = BOOT;
            default: state_next = BOOT;
         endcase
      end
   end

   assign mode = state;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         strcnt <= '0;
      end else begin
         strcnt <= strcnt + STRPRE'(1);
      end
   end

   assign tick = &strcnt;

   // A fresh event always restarts the full stretch, even on a tick clock
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < 8; i++) begin
            scnt[i] <= 3'd0;
         end
      end else begin
         for (int i = 0; i < 8; i++) begin
            if (event_pulse[i]) begin
               scnt[i] <= 3'(STRLEN);
            end else if (tick && (scnt[i] != 3'd0)) begin
               scnt[i] <= scnt[i] - 3'd1;
            end
         end
      end
   end

   always_comb begin
      flash = 8'h00;
      for (int i = 0; i < 8; i++) begin
         flash[i] = (scnt[i] != 3'd0);
      end
   end

   generate
      if (PWMPRE == 0) begin : g_nopre
         assign pwm_step = 1'b1;
      end else begin : g_pre
         logic [PWMPRE-1:0] pscnt;
         always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
               pscnt <= '0;
            end else begin
               pscnt <= pscnt + PWMPRE'(1);
            end
         end
         assign pwm_step = &pscnt;
      end
   endgenerate

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         pwm <= 3'd0;
      end else if (pwm_step) begin
         pwm <= pwm + 3'd1;
      end
   end

   assign on = (pwm <= bright);

   always_comb begin
      pattern = cylon_q;
      lit     = on;
      case (state)
         BOOT: pattern = cylon_q;
         RUN:  pattern = status ^ flash;
         LAMP: begin
            pattern = 8'hFF;
            lit     = 1'b1;
         end
         default: pattern = cylon_q;
      endcase
      led_next = pattern & {8{lit}};
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         led <= LED_OFF;
      end else begin
         led <= LED_ACTIVE_LOW ? ~led_next : led_next;
      end
   end

endmodule

// File: tb/tb_led_panel_driver.sv
// Self-checking bench for led_panel_driver: vector tables, directed corner
// sequences and a randomized phase against a cycle-indexed reference model.
module tb_led_panel_driver;

   localparam int PWMPRE = 0;
   localparam int STRPRE = 2;
   localparam int STRLEN = 3;
   localparam int DBNC   = 4;
   localparam int TICKP  = 1 << STRPRE;

   logic       clock = 1'b0;
   logic       reset_n;
   logic [7:0] cylon_q;
   logic [7:0] status;
   logic       status_vld;
   logic [7:0] event_pulse;
   logic       lamp_test;
   logic [2:0] bright;
   logic [7:0] led;
   logic [1:0] mode;

   int tests    = 0;
   int failures = 0;

   led_panel_driver #(
      .PWMPRE(PWMPRE),
      .STRPRE(STRPRE),
      .STRLEN(STRLEN),
      .DBNC(DBNC),
      .LED_ACTIVE_LOW(1'b1)
   ) dut (
      .clock(clock),
      .reset_n(reset_n),
      .cylon_q(cylon_q),
      .status(status),
      .status_vld(status_vld),
      .event_pulse(event_pulse),
      .lamp_test(lamp_test),
      .bright(bright),
      .led(led),
      .mode(mode)
   );

   always #5 clock = ~clock;

   // Reference model: n counts edges since reset release; everything is derived
   // from that index, the per-LED edge of the last event and the valid history.
   int         n;
   bit         vld_db_m;
   int         state_m;
   int         last_evt [8];
   bit         vhist [$];
   logic [7:0] exp_led;
   logic [1:0] exp_mode;

   function automatic int ticksIn(input int a, input int b);
      if (b < a) return 0;
      return (b / TICKP) - ((a - 1) / TICKP);
   endfunction

   task automatic modelReset();
      n        = 0;
      vld_db_m = 1'b0;
      state_m  = 0;
      for (int i = 0; i < 8; i++) last_evt[i] = -1;
      vhist.delete();
      exp_led  = 8'hFF;
      exp_mode = 2'd0;
   endtask

   task automatic modelStep();
      logic [7:0] fl;
      logic [7:0] pat;
      bit         lt;
      bit         differ;
      n++;
      fl = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (last_evt[i] > 0 && ticksIn(last_evt[i] + 1, n - 1) < STRLEN) fl[i] = 1'b1;
      end
      lt = ((((n - 1) >> PWMPRE) % 8) <= int'(bright));
      case (state_m)
         0:       pat = cylon_q;
         1:       pat = status ^ fl;
         default: begin pat = 8'hFF; lt = 1'b1; end
      endcase
      exp_led = ~(lt ? pat : 8'h00);
      for (int i = 0; i < 8; i++) if (event_pulse[i]) last_evt[i] = n;
      if (lamp_test) state_m = 2;
      else           state_m = vld_db_m ? 1 : 0;
      vhist.push_back(status_vld);
      if (vhist.size() >= DBNC) begin
         differ = 1'b1;
         for (int k = 0; k < DBNC; k++) begin
            if (vhist[vhist.size() - 1 - k] == vld_db_m) differ = 1'b0;
         end
         if (differ) vld_db_m = ~vld_db_m;
      end
      exp_mode = 2'(state_m);
   endtask

   task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
      tests++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %h, expected %h (edge %0d)", name, act, exp, n);
      end
   endtask

   task automatic checkRange(input string name, input int act, input int lo, input int hi);
      tests++;
      if (act < lo || act > hi) begin
         failures++;
         $display("[TB] FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
      end
   endtask

   task automatic applyStimulus(input logic [7:0] cyl, input logic [7:0] st, input logic vld,
                                input logic [7:0] ev, input logic lamp, input logic [2:0] br);
      cylon_q     = cyl;
      status      = st;
      status_vld  = vld;
      event_pulse = ev;
      lamp_test   = lamp;
      bright      = br;
   endtask

   task automatic stepClock();
      @(posedge clock);
      modelStep();
      #1;
      checkOutput("model led", led, exp_led);
      checkOutput("model mode", {6'b0, mode}, {6'b0, exp_mode});
   endtask

   task automatic stepN(input int k);
      for (int i = 0; i < k; i++) stepClock();
   endtask

   typedef struct {
      logic [7:0] stim;
      logic [7:0] expLed;
   } vec_t;

   vec_t bootVec [4];
   vec_t runVec  [4];

   initial begin
      int litCount;

      bootVec[0] = '{8'h41, 8'hBE};
      bootVec[1] = '{8'hFF, 8'h00};
      bootVec[2] = '{8'h00, 8'hFF};
      bootVec[3] = '{8'hA5, 8'h5A};
      runVec[0]  = '{8'h00, 8'hFF};
      runVec[1]  = '{8'hFF, 8'h00};
      runVec[2]  = '{8'h81, 8'h7E};
      runVec[3]  = '{8'h3C, 8'hC3};

      reset_n = 1'b0;
      applyStimulus(8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 3'd7);
      modelReset();
      #12;
      checkOutput("reset led", led, 8'hFF);
      checkOutput("reset mode", {6'b0, mode}, 8'h00);
      @(negedge clock);
      reset_n = 1'b1;

      applyStimulus(8'h41, 8'h00, 1'b0, 8'h00, 1'b0, 3'd7);
      stepClock();
      checkOutput("boot first pattern", led, 8'hBE);

      for (int i = 0; i < 4; i++) begin
         applyStimulus(bootVec[i].stim, 8'h00, 1'b0, 8'h00, 1'b0, 3'd7);
         stepClock();
         checkOutput("boot table", led, bootVec[i].expLed);
      end

      // Short valid glitch must not change mode
      applyStimulus(8'h00, 8'h3C, 1'b1, 8'h00, 1'b0, 3'd7);
      stepN(3);
      status_vld = 1'b0;
      stepN(5);
      checkOutput("glitch mode", {6'b0, mode}, 8'h00);

      status_vld = 1'b1;
      stepN(4);
      checkOutput("debounce mode after 4", {6'b0, mode}, 8'h00);
      stepClock();
      checkOutput("debounce mode after 5", {6'b0, mode}, 8'h01);
      stepClock();
      checkOutput("run led", led, 8'hC3);

      for (int i = 0; i < 4; i++) begin
         applyStimulus(8'h00, runVec[i].stim, 1'b1, 8'h00, 1'b0, 3'd7);
         stepClock();
         checkOutput("run table", led, runVec[i].expLed);
      end

      // Single event stretch
      applyStimulus(8'h00, 8'h00, 1'b1, 8'h00, 1'b0, 3'd7);
      stepN(20);
      event_pulse = 8'h01;
      stepClock();
      checkOutput("flash latency", led, 8'hFF);
      event_pulse = 8'h00;
      litCount = 0;
      for (int k = 0; k < 30; k++) begin
         stepClock();
         if (led[0] == 1'b0) litCount++;
         else break;
      end
      checkRange("single stretch length", litCount, 9, 12);

      // Re-trigger five edges into a stretch
      stepN(20);
      event_pulse = 8'h01;
      stepClock();
      event_pulse = 8'h00;
      litCount = 0;
      for (int k = 0; k < 4; k++) begin
         stepClock();
         if (led[0] == 1'b0) litCount++;
      end
      event_pulse = 8'h01;
      stepClock();
      if (led[0] == 1'b0) litCount++;
      event_pulse = 8'h00;
      for (int k = 0; k < 30; k++) begin
         stepClock();
         if (led[0] == 1'b0) litCount++;
         else break;
      end
      checkRange("restarted stretch length", litCount, 14, 17);

      // PWM duty over one full period
      stepN(20);
      status = 8'hFF;
      bright = 3'd2;
      litCount = 0;
      for (int k = 0; k < 8; k++) begin
         stepClock();
         if (led == 8'h00) litCount++;
      end
      checkRange("pwm bright 2", litCount, 3, 3);
      bright = 3'd0;
      litCount = 0;
      for (int k = 0; k < 8; k++) begin
         stepClock();
         if (led == 8'h00) litCount++;
      end
      checkRange("pwm bright 0", litCount, 1, 1);
      bright = 3'd7;
      litCount = 0;
      for (int k = 0; k < 8; k++) begin
         stepClock();
         if (led == 8'h00) litCount++;
      end
      checkRange("pwm bright 7", litCount, 8, 8);

      // Lamp test entry and both exits
      bright    = 3'd0;
      lamp_test = 1'b1;
      stepN(2);
      checkOutput("lamp led", led, 8'h00);
      checkOutput("lamp mode", {6'b0, mode}, 8'h02);
      lamp_test = 1'b0;
      stepClock();
      checkOutput("lamp exit to run", {6'b0, mode}, 8'h01);
      lamp_test = 1'b1;
      stepClock();
      status_vld = 1'b0;
      stepN(5);
      checkOutput("lamp holds", {6'b0, mode}, 8'h02);
      lamp_test = 1'b0;
      stepClock();
      checkOutput("lamp exit to boot", {6'b0, mode}, 8'h00);

      // Asynchronous reset mid-stretch and mid-debounce
      applyStimulus(8'h00, 8'h00, 1'b1, 8'h00, 1'b0, 3'd7);
      stepN(6);
      checkOutput("rerun mode", {6'b0, mode}, 8'h01);
      event_pulse = 8'hFF;
      stepClock();
      event_pulse = 8'h00;
      stepN(3);
      status_vld = 1'b0;
      stepN(2);
      #2;
      reset_n = 1'b0;
      #1;
      checkOutput("async reset led", led, 8'hFF);
      checkOutput("async reset mode", {6'b0, mode}, 8'h00);
      modelReset();
      @(negedge clock);
      @(negedge clock);
      applyStimulus(8'h00, 8'h00, 1'b1, 8'h00, 1'b0, 3'd7);
      reset_n = 1'b1;
      for (int k = 0; k < 15; k++) begin
         stepClock();
         checkOutput("no flash after reset", led, 8'hFF);
      end

      // Randomized phase
      for (int k = 0; k < 600; k++) begin
         cylon_q = 8'($urandom);
         status  = 8'($urandom);
         if ($urandom_range(9, 0) == 0) status_vld = ~status_vld;
         if ($urandom_range(39, 0) == 0) lamp_test = ~lamp_test;
         if ($urandom_range(29, 0) == 0) bright = 3'($urandom);
         if ($urandom_range(5, 0) == 0) event_pulse = 8'($urandom) & 8'($urandom);
         else event_pulse = 8'h00;
         stepClock();
      end

      $display("[TB] %0d tests run, %0d failed", tests, failures);
      $finish;
   end

endmodule
